// File: rtl/ccm_pkg.sv
// Shared CCM definitions: access-size codes, response-owner state and the request legality check.
// Pure declarations; no latency or backpressure of its own.
package ccm_pkg;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SB      = 2'b01;
    localparam logic [1:0] SH      = 2'b10;
    localparam logic [1:0] SW      = 2'b11;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IFU  = 2'd1,
        OWN_LSU  = 2'd2
    } rsp_owner_e;

    // Request attributes that must survive into the response cycle.
    typedef struct packed {
        logic [1:0] size;
        logic       uns;
        logic [1:0] offset;
        logic       we;
        logic       err;
    } rsp_meta_t;

    // aw is the word-address width; the byte address may use bits [aw+1:0] only.
    function automatic logic req_illegal(
        input logic [31:0] addr,
        input logic [1:0]  size,
        input int unsigned aw
    );
        logic misaligned;
        logic out_of_range;
        misaligned   = ((size == SH) && addr[0]) ||
                       ((size == SW) && (addr[1:0] != 2'b00));
        out_of_range = (aw < 32'd30) ? ((addr >> (aw + 32'd2)) != 32'd0) : 1'b0;
        return misaligned || out_of_range || (size == SZ_NONE);
    endfunction

endpackage

// File: rtl/ccm_port_arbiter_if.sv
// Request/response handshakes of both CCM requesters plus the memory-macro port.
// master = requesters and macro side, slave = arbiter side.
interface ccm_port_arbiter_if;

    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;
    logic        ifu_rsp_err;

    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_req_addr;
    logic        lsu_req_we;
    logic [1:0]  lsu_req_size;
    logic        lsu_req_unsigned;
    logic [31:0] lsu_req_wdata;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rsp_data;
    logic        lsu_rsp_err;

    logic [31:0] mem_adr;
    logic [31:0] mem_d;
    logic [1:0]  mem_store_type;
    logic [1:0]  mem_store_offset;
    logic        mem_we;
    logic [31:0] mem_q;

    modport master (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
        output lsu_req_valid, lsu_req_addr, lsu_req_we, lsu_req_size,
               lsu_req_unsigned, lsu_req_wdata,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err,
        input  mem_adr, mem_d, mem_store_type, mem_store_offset, mem_we,
        output mem_q
    );

    modport slave (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
        input  lsu_req_valid, lsu_req_addr, lsu_req_we, lsu_req_size,
               lsu_req_unsigned, lsu_req_wdata,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err,
        output mem_adr, mem_d, mem_store_type, mem_store_offset, mem_we,
        input  mem_q
    );

endinterface

// File: rtl/ccm_load_align.sv
// Extracts a byte/half/word lane from a memory word and sign- or zero-extends it.
// Purely combinational, zero latency, no handshake.
module ccm_load_align
    import ccm_pkg::*;
(
    input  logic [31:0] i_mem_q,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_mem_q[{i_offset, 3'b000} +: 8];
        w_half = i_mem_q[{i_offset[1], 4'b0000} +: 16];
        case (i_size)
            SB:      o_data = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SH:      o_data = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: o_data = i_mem_q;
        endcase
    end

endmodule

// File: rtl/ccm_port_arbiter.sv
// Arbitrates IFU/LSU onto the single-port CCM with an IFU starvation guard; response one cycle after accept.
// Grant decided combinationally each cycle (ready only to the winner); responses have no backpressure.
module ccm_port_arbiter
    import ccm_pkg::*;
#(
    parameter int unsigned AW       = 16,
    parameter int unsigned MAX_WAIT = 4
)(
    input  logic               clk,
    input  logic               rst_n,
    ccm_port_arbiter_if.slave  bus
);

    localparam int unsigned WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    rsp_owner_e     r_rsp_owner;
    rsp_owner_e     w_rsp_owner_nxt;
    rsp_meta_t      r_meta;
    rsp_meta_t      w_meta_nxt;
    logic [WCW-1:0] r_wait_cnt;

    logic        w_ifu_illegal;
    logic        w_lsu_illegal;
    logic        w_ifu_force;
    logic        w_gnt_ifu;
    logic        w_gnt_lsu;
    logic [31:0] w_load_dat;
    logic        w_ifu_rsp_vld;
    logic        w_lsu_rsp_vld;

    assign w_ifu_illegal = req_illegal(bus.ifu_req_addr, SW, AW);
    assign w_lsu_illegal = req_illegal(bus.lsu_req_addr, bus.lsu_req_size, AW);

    // Gating with rst_n keeps ready and mem_we low throughout reset, even with valid held high.
    assign w_ifu_force = (r_wait_cnt == WCW'(MAX_WAIT));
    assign w_gnt_lsu   = rst_n & bus.lsu_req_valid & ~(w_ifu_force & bus.ifu_req_valid);
    assign w_gnt_ifu   = rst_n & bus.ifu_req_valid & ~w_gnt_lsu;

    assign bus.ifu_req_ready = w_gnt_ifu;
    assign bus.lsu_req_ready = w_gnt_lsu;

    always_comb begin
        bus.mem_adr          = 32'd0;
        bus.mem_d            = 32'd0;
        bus.mem_store_type   = 2'b00;
        bus.mem_store_offset = 2'b00;
        bus.mem_we           = 1'b0;
        if (w_gnt_lsu) begin
            bus.mem_adr          = 32'(bus.lsu_req_addr[AW+1:2]);
            bus.mem_store_offset = bus.lsu_req_addr[1:0];
            if (bus.lsu_req_we && !w_lsu_illegal) begin
                bus.mem_we         = 1'b1;
                bus.mem_d          = bus.lsu_req_wdata;
                bus.mem_store_type = bus.lsu_req_size;
            end
        end else if (w_gnt_ifu) begin
            bus.mem_adr          = 32'(bus.ifu_req_addr[AW+1:2]);
            bus.mem_store_offset = bus.ifu_req_addr[1:0];
        end
    end

    // Response owner: every cycle records who was granted, so a response lasts exactly one cycle.
    always_comb begin
        w_rsp_owner_nxt = OWN_NONE;
        w_meta_nxt      = '0;
        if (w_gnt_lsu) begin
            w_rsp_owner_nxt   = OWN_LSU;
            w_meta_nxt.size   = bus.lsu_req_size;
            w_meta_nxt.uns    = bus.lsu_req_unsigned;
            w_meta_nxt.offset = bus.lsu_req_addr[1:0];
            w_meta_nxt.we     = bus.lsu_req_we;
            w_meta_nxt.err    = w_lsu_illegal;
        end else if (w_gnt_ifu) begin
            w_rsp_owner_nxt   = OWN_IFU;
            w_meta_nxt.size   = SW;
            w_meta_nxt.err    = w_ifu_illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_owner <= OWN_NONE;
            r_meta      <= '0;
        end else begin
            r_rsp_owner <= w_rsp_owner_nxt;
            r_meta      <= w_meta_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (!bus.ifu_req_valid || w_gnt_ifu) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt < WCW'(MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + WCW'(1);
        end
    end

    ccm_load_align u_load_align (
        .i_mem_q    (bus.mem_q),
        .i_offset   (r_meta.offset),
        .i_size     (r_meta.size),
        .i_unsigned (r_meta.uns),
        .o_data     (w_load_dat)
    );

    assign w_ifu_rsp_vld = (r_rsp_owner == OWN_IFU);
    assign w_lsu_rsp_vld = (r_rsp_owner == OWN_LSU);

    assign bus.ifu_rsp_valid = w_ifu_rsp_vld;
    assign bus.ifu_rsp_err   = w_ifu_rsp_vld & r_meta.err;
    assign bus.ifu_rsp_data  = (w_ifu_rsp_vld && !r_meta.err) ? bus.mem_q : 32'd0;

    assign bus.lsu_rsp_valid = w_lsu_rsp_vld;
    assign bus.lsu_rsp_err   = w_lsu_rsp_vld & r_meta.err;
    assign bus.lsu_rsp_data  = (w_lsu_rsp_vld && !r_meta.err && !r_meta.we) ? w_load_dat : 32'd0;

endmodule

// File: doc/ccm_port_arbiter.md
# ccm_port_arbiter

Shares the single-port closely-coupled memory (CCM, 32-bit words, one-cycle registered read, SB/SH/SW byte-lane writes) between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It sits between both requesters and the memory macro, and performs per-cycle arbitration with a starvation guard. It also converts byte addresses to word addresses, checks alignment and range, and returns sign- or zero-extended load data one cycle after acceptance.

## Interface
- AW, 16: CCM word-address width (depth 2^AW words).
- MAX_WAIT, 4: consecutive stalled IFU cycles before the IFU is forced priority.
- CLK  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ifu_req_valid / ifu_req_ready  in / out  1  fetch request handshake.
- ifu_req_addr  in  32  byte address.
- ifu_rsp_valid  out  1  fetch response strobe; no backpressure.
- ifu_rsp_data  out  32  fetched word.
- ifu_rsp_err  out  1  misaligned or out-of-range fetch.
- lsu_req_valid / lsu_req_ready  in / out  1  load/store handshake.
- lsu_req_addr  in  32  byte address.
- lsu_req_we  in  1  1 = store.
- lsu_req_size  in  2  01 byte, 10 half, 11 word; 00 is illegal.
- lsu_req_unsigned  in  1  zero-extend load (LBU/LHU).
- lsu_req_wdata  in  32  store data, right-justified.
- lsu_rsp_valid  out  1  response strobe for loads and store acknowledgements; no backpressure.
- lsu_rsp_data  out  32  extended load data; 0 for stores.
- lsu_rsp_err  out  1  error flag.
- mem_adr  out  32  word address, {zeros, addr[AW+1:2]}.
- mem_d  out  32  store data.
- mem_store_type  out  2  lsu_req_size on stores.
- mem_store_offset  out  2  addr[1:0].
- mem_we  out  1  write enable.
- mem_q  in  32  registered read data, valid the cycle after a read.

## Operation
- Legality check per request:
  - misaligned: half with addr[0]=1, word/IFU with addr[1:0]≠0;
  - out-of-range: addr[31:AW+2]≠0;
  - size 00.
- Any of these makes the request illegal.
- Illegal requests are accepted but never drive mem_we=1. They get a response with err=1 and data=0.
- Arbitration is decided in the same cycle: ready is high only for the granted requester. At most one grant per cycle.
- Default priority is LSU over IFU.
- wait_cnt (saturating, width clog2(MAX_WAIT+1)):
  - increments each cycle ifu_req_valid=1 and the IFU is not granted;
  - clears on IFU grant or when ifu_req_valid=0.
- When wait_cnt==MAX_WAIT, the IFU wins over the LSU.
- Memory drive on grant is combinational from the granted request. mem_we=1 only for a legal LSU store. Otherwise it is a read.
- Response state register rsp_owner ∈ {NONE, IFU, LSU}. It is loaded every cycle with the grantee, or NONE if there is no grant.
- Alongside rsp_owner, the block latches size, unsigned, offset, we and err.
- LSU load data is extracted from mem_q by the latched offset and size, then sign- or zero-extended.
- Reset: rsp_owner=NONE, wait_cnt=0, all valid/ready/mem_we outputs 0.
- Reset asserted with a response pending: the response is dropped, never emitted.

## Timing
- Request accepted in cycle t (valid & ready) → response valid in cycle t+1, for exactly one cycle.
- Response data is combinational from mem_q and the latched state.
- Throughput is one access per cycle, back-to-back, for either requester.
- A store writes at the rising edge ending cycle t. A load granted at t+1 to the same word returns the new data.
- ready may be high while the other requester's response is being emitted.
- A requester must hold valid and all request fields stable until ready.

## Structure
- Shared package ccm_pkg holds:
  - size/store-type constants SB=01, SH=10, SW=11;
  - the rsp_owner enum;
  - a legality-check function.
- Sub-module ccm_load_align: combinational inputs mem_q, offset, size, unsigned → 32-bit extended data. It is reused later by the DMA path.

## Test plan
- LSU SW 0xDEADBEEF at 0x10, then LB at 0x13 → t+1 rdata 0xFFFFFFDE; LBU at 0x13 → 0x000000DE; LH at 0x12 → 0xFFFFDEAD.
- SB 0x55 at 0x11 over 0x11223344, then LW 0x10 → 0x11225544; no other lanes change.
- Both requesters valid continuously → IFU granted exactly every (MAX_WAIT+1)th cycle; the LSU gets all other cycles.
- LW at 0x02, LH at 0x01, IFU at 0x06, address 0x00040000 with AW=16 → err=1, data 0, mem_we never 1.
- Store to 0x20 in cycle t and load from 0x20 in t+1 → load returns the new data; both responses are single-cycle.
- rst_n dropped in the cycle after a load grant → no rsp_valid; all outputs 0 asynchronously; clean grant after release.
